sr_latch_bank: RTL
==================

// Module: sr_latch_bank
// PURPOSE
//  Parametrised successor to the discrete 7402 NOR set/reset latch. Provides CHANNELS
//  independent set/reset latches fed by bouncy, active-low panel switches (_Set/_Reset).
//  Each switch input is synchronised and debounced, then drives a clocked latch with a
//  selectable contention mode. Q/nQ drive LEDs or downstream logic; Changed flags edges.
// PARAMETERS
//  CHANNELS         4    number of independent latches (1..32)
//  DEBOUNCE_CYCLES  16   consecutive stable clocks required to accept a switch level (>=1)
//  MODE             0    0 = NOR-equivalent, 1 = set-dominant, 2 = reset-dominant
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived; do not override)
// PORTS
//  Clk      input   1         system clock; all state updates on rising edge
//  Reset    input   1         asynchronous, active-high reset
//  _Set     input   CHANNELS  raw active-low set switches (asynchronous, bouncy)
//  _Reset   input   CHANNELS  raw active-low reset switches (asynchronous, bouncy)
//  Q        output  CHANNELS  latch true output
//  nQ       output  CHANNELS  latch complementary output (not always ~Q, see MODE 0)
//  Changed  output  CHANNELS  one-clock pulse when Q[i] changes value
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops = 1, filtered levels = 1 (inactive),
//   counters = 0, stored state = 0; Q = 0, nQ = 1, Changed = 0.
//  Sync: each raw input passes through 2 flops before use; no logic on the raw pin.
//  Debounce, per input: filtered level F, counter C.
//   - sync value == F: C <= 0.
//   - sync value != F: C <= C+1; when C == DEBOUNCE_CYCLES-1, F <= sync value and C <= 0.
//   - Any return to F before acceptance clears C (glitch is discarded, no partial credit).
//  Latch, per channel (S = ~F_set, R = ~F_reset, active-high internally); state bit M:
//   - S & ~R: M <= 1.  ~S & R: M <= 0.  ~S & ~R: M holds.
//   - S & R, MODE 0: M holds; outputs forced Q = 0, nQ = 0 (NOR behaviour).
//     On simultaneous release, outputs return to M: deterministic, never oscillate.
//   - S & R, MODE 1: M <= 1.  MODE 2: M <= 0.
//  Outputs registered: Q = (MODE==0 & S & R) ? 0 : M; nQ = (MODE==0 & S & R) ? 0 : ~M.
//  Latency: clean switch edge -> Q update = DEBOUNCE_CYCLES + 3 clocks
//   (2 sync + DEBOUNCE_CYCLES to accept + 1 output register).
//  Changed[i] = Q[i] differs from its previous registered value; 1-clock pulse, registered
//   alongside Q. The MODE 0 contention entry/exit that moves Q also pulses Changed.
//  Reset mid-debounce or mid-contention: all state cleared immediately. A switch held
//   through reset release is re-debounced from scratch: full latency, no shortcut.
//  Channels are fully independent; no cross-channel priority or shared counters.
//  Illegal MODE (>2): elaboration error via generate-time check.
// STRUCTURE
//  Shared package sr_latch_pkg: MODE constants (SRL_MODE_NOR=0, SRL_MODE_SET_DOM=1,
//   SRL_MODE_RST_DOM=2) and a function computing CNT_W from DEBOUNCE_CYCLES.
//  Sub-module switch_debouncer (params DEBOUNCE_CYCLES, CNT_W; ports Clk, Reset, raw_n,
//   level_n): 2-flop sync + counter. Instantiated 2*CHANNELS times via generate.
//  Latch/mode logic and Changed detection live in sr_latch_bank in a per-channel generate loop.
// TESTING
//  1. Reset asserted mid-clock with inputs idle -> Q=0, nQ=1, Changed=0 immediately (async).
//  2. DEBOUNCE_CYCLES=16: hold _Set[0]=0 cleanly -> Q[0]=1 exactly 19 clocks later;
//     Changed[0] high for exactly 1 clock; other channels unchanged.
//  3. Bounce: _Set[1] pulses low 15 clocks, high 1, low 20 -> Q[1] rises 19 clocks after the
//     final falling edge; no earlier change, single Changed pulse.
//  4. MODE 0: Q=1, then assert both _Set/_Reset -> Q=0, nQ=0; release _Reset first -> Q=1,
//     nQ=0; repeat with simultaneous release -> Q returns to stored M, no toggling.
//  5. MODE 1 and MODE 2 builds: both asserted from Q=0 and from Q=1 -> Q=1 (set-dom) /
//     Q=0 (rst-dom); nQ always ~Q.
//  6. Reset pulse while _Set held low and counter at 10 -> Q=0 after reset; Q=1 again a full
//     19 clocks after reset release; CHANNELS=1 and DEBOUNCE_CYCLES=1 builds pass 2-4.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// rtl/sr_latch_pkg.sv - shared constants and helpers for the set/reset latch bank
// Purpose: contention-mode encodings and the debounce counter width helper.
// Ports:   none (package).
package sr_latch_pkg;

   localparam int SRL_MODE_NOR     = 0;
   localparam int SRL_MODE_SET_DOM = 1;
   localparam int SRL_MODE_RST_DOM = 2;

   typedef enum logic [1:0] {
      SRL_NOR     = 2'd0,
      SRL_SET_DOM = 2'd1,
      SRL_RST_DOM = 2'd2
   } srl_mode_e;

   // Counter must be able to hold DEBOUNCE_CYCLES; clamp so a 1-cycle filter still gets 1 bit.
   function automatic int srl_cnt_w(input int debounce_cycles);
      if (debounce_cycles < 1)
         return 1;
      return $clog2(debounce_cycles + 1);
   endfunction

endpackage

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser plus stable-level debounce filter
// Purpose: accepts a new level of an asynchronous, bouncy active-low switch only after
//          DEBOUNCE_CYCLES consecutive synchronised samples at that new level.
// Ports:   Clk      - system clock
//          Reset    - asynchronous active-high reset
//          raw_n    - raw active-low switch pin
//          level_n  - filtered active-low level (1 = inactive after reset)
module switch_debouncer
   import sr_latch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = srl_cnt_w(DEBOUNCE_CYCLES)
) (
   input  logic Clk,
   input  logic Reset,
   input  logic raw_n,
   output logic level_n
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         level_n <= 1'b1;
         cnt     <= '0;
      end else begin
         sync1 <= raw_n;
         sync2 <= sync1;
         // Any sample matching the accepted level discards partial progress.
         if (sync2 == level_n) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level_n <= sync2;
            cnt     <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sr_latch_bank.sv
// rtl/sr_latch_bank.sv - bank of debounced set/reset latches with selectable contention mode
// Purpose: CHANNELS independent latches driven by active-low panel switches. MODE selects
//          behaviour when set and reset are both active: 0 = NOR (both outputs low, state
//          held), 1 = set-dominant, 2 = reset-dominant.
// Ports:   Clk      - system clock
//          Reset    - asynchronous active-high reset
//          _Set     - raw active-low set switches, one per channel
//          _Reset   - raw active-low reset switches, one per channel
//          Q        - registered latch output
//          nQ       - registered complementary output (both low during NOR contention)
//          Changed  - one-clock pulse whenever Q[i] changes
module sr_latch_bank
   import sr_latch_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MODE            = SRL_MODE_NOR,
   parameter int CNT_W           = srl_cnt_w(DEBOUNCE_CYCLES)
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [CHANNELS-1:0] _Set,
   input  logic [CHANNELS-1:0] _Reset,
   output logic [CHANNELS-1:0] Q,
   output logic [CHANNELS-1:0] nQ,
   output logic [CHANNELS-1:0] Changed
);

   generate
      if (MODE < SRL_MODE_NOR || MODE > SRL_MODE_RST_DOM) begin : g_bad_mode
         $error("sr_latch_bank: illegal MODE %0d", MODE);
      end
      if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
         $error("sr_latch_bank: CHANNELS %0d out of range 1..32", CHANNELS);
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
         $error("sr_latch_bank: DEBOUNCE_CYCLES must be at least 1");
      end
   endgenerate

   logic [CHANNELS-1:0] set_lvl_n;
   logic [CHANNELS-1:0] rst_lvl_n;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic m;
      logic m_next;
      logic s;
      logic r;
      logic contend;
      logic q_next;

      switch_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db_set (
         .Clk    (Clk),
         .Reset  (Reset),
         .raw_n  (_Set[i]),
         .level_n(set_lvl_n[i])
      );

      switch_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db_rst (
         .Clk    (Clk),
         .Reset  (Reset),
         .raw_n  (_Reset[i]),
         .level_n(rst_lvl_n[i])
      );

      always_comb begin
         s       = ~set_lvl_n[i];
         r       = ~rst_lvl_n[i];
         m_next  = m;
         contend = 1'b0;
         if (s && !r) begin
            m_next = 1'b1;
         end else if (!s && r) begin
            m_next = 1'b0;
         end else if (s && r) begin
            if (MODE == SRL_MODE_SET_DOM)
               m_next = 1'b1;
            else if (MODE == SRL_MODE_RST_DOM)
               m_next = 1'b0;
            else
               contend = 1'b1;   // NOR: state held, both outputs pulled low
         end
         q_next = contend ? 1'b0 : m_next;
      end

      // Outputs are registered from the next state so Q moves on the same edge as M.
      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) begin
            m          <= 1'b0;
            Q[i]       <= 1'b0;
            nQ[i]      <= 1'b1;
            Changed[i] <= 1'b0;
         end else begin
            m          <= m_next;
            Q[i]       <= q_next;
            nQ[i]      <= contend ? 1'b0 : ~m_next;
            Changed[i] <= (q_next != Q[i]);
         end
      end
   end

endmodule
